// File: rtl/window_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// window_seq_ctrl_if
// Groups the handshake and stripe-buffer signals of window_seq_ctrl.
//   master : the controller side (drives strobes, addresses, status)
//   slave  : the environment side (upstream source, sink, frame control)
// Signals:
//   start, abort       frame control requests
//   in_valid/in_ready  upstream pixel handshake
//   out_ready          sink accepts a window one cycle later
//   mem_wr, wr_addr    stripe buffer write port
//   mem_rd, win_base   stripe buffer 3x3 window read port
//   out_valid          window pixels valid at buffer outputs
//   stripe_idx, busy, stripe_done, frame_done  progress/status
// -----------------------------------------------------------------------------
interface window_seq_ctrl_if;
    logic        start;
    logic        abort;
    logic        in_valid;
    logic        in_ready;
    logic        out_ready;
    logic        mem_wr;
    logic [13:0] wr_addr;
    logic        mem_rd;
    logic [13:0] win_base;
    logic        out_valid;
    logic [2:0]  stripe_idx;
    logic        busy;
    logic        stripe_done;
    logic        frame_done;

    modport master (
        input  start, abort, in_valid, out_ready,
        output in_ready, mem_wr, wr_addr, mem_rd, win_base, out_valid,
               stripe_idx, busy, stripe_done, frame_done
    );

    modport slave (
        output start, abort, in_valid, out_ready,
        input  in_ready, mem_wr, wr_addr, mem_rd, win_base, out_valid,
               stripe_idx, busy, stripe_done, frame_done
    );
endinterface

// File: rtl/window_seq_ctrl.sv
// -----------------------------------------------------------------------------
// window_seq_ctrl
// Sequences a frame as NUM_STRIPES stripes. Each stripe is first loaded into a
// padded stripe buffer (PAD_W x (OUT_ROWS+2) pixels), then swept as
// IMG_W x OUT_ROWS overlapping 3x3 windows addressed by their top-left pixel.
// Ports:
//   clk  : sole clock, all state on the rising edge
//   rst  : synchronous active-high reset
//   bus  : window_seq_ctrl_if.master (handshakes, buffer strobes, status)
// -----------------------------------------------------------------------------
module window_seq_ctrl #(
    parameter int PAD_W       = 258,
    parameter int IMG_W       = 256,
    parameter int OUT_ROWS    = 32,
    parameter int NUM_STRIPES = 8
) (
    input  logic              clk,
    input  logic              rst,
    window_seq_ctrl_if.master bus
);

    localparam int ADDR_W = 14;
    localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W  = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1;

    localparam logic [ADDR_W-1:0] LAST_WR     = ADDR_W'(PAD_W * (OUT_ROWS + 2) - 1);
    localparam logic [COL_W-1:0]  LAST_COL    = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW    = ROW_W'(OUT_ROWS - 1);
    localparam logic [2:0]        LAST_STRIPE = 3'(NUM_STRIPES - 1);
    // Jump from the last window of a row to the first of the next row:
    // (row+1)*PAD_W - (row*PAD_W + IMG_W-1), which keeps win_base multiplier-free.
    localparam logic [ADDR_W-1:0] ROW_STEP    = ADDR_W'(PAD_W - IMG_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SWEEP = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] win_base_q, win_base_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [2:0]        stripe_idx_q, stripe_idx_d;
    logic              out_valid_q;

    logic in_ready, mem_wr, mem_rd, stripe_done, frame_done;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case leaves it unassigned and no latch is inferred.
        state_d      = state_q;
        wr_addr_d    = wr_addr_q;
        win_base_d   = win_base_q;
        col_d        = col_q;
        row_d        = row_q;
        stripe_idx_d = stripe_idx_q;
        in_ready     = 1'b0;
        mem_wr       = 1'b0;
        mem_rd       = 1'b0;
        stripe_done  = 1'b0;
        frame_done   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d      = LOAD;
                    wr_addr_d    = '0;
                    win_base_d   = '0;
                    col_d        = '0;
                    row_d        = '0;
                    stripe_idx_d = '0;
                end
            end

            LOAD: begin
                in_ready = 1'b1;
                mem_wr   = bus.in_valid;
                if (bus.in_valid) begin
                    if (wr_addr_q == LAST_WR) begin
                        wr_addr_d = '0;
                        state_d   = SWEEP;
                    end else begin
                        wr_addr_d = wr_addr_q + 1'b1;
                    end
                end
            end

            SWEEP: begin
                mem_rd = bus.out_ready;
                if (bus.out_ready) begin
                    if (col_q == LAST_COL) begin
                        col_d = '0;
                        if (row_q == LAST_ROW) begin
                            // Last window of the stripe: rewind for the next one.
                            row_d       = '0;
                            win_base_d  = '0;
                            stripe_done = 1'b1;
                            state_d     = DRAIN;
                        end else begin
                            row_d      = row_q + 1'b1;
                            win_base_d = win_base_q + ROW_STEP;
                        end
                    end else begin
                        col_d      = col_q + 1'b1;
                        win_base_d = win_base_q + 1'b1;
                    end
                end
            end

            DRAIN: begin
                // The final window's out_valid is presented during this cycle.
                if (stripe_idx_q == LAST_STRIPE) begin
                    frame_done = 1'b1;
                    state_d    = IDLE;
                end else begin
                    stripe_idx_d = stripe_idx_q + 1'b1;
                    state_d      = LOAD;
                end
            end

            default: state_d = IDLE;
        endcase

        // A cancelled cycle never reports completion.
        if (bus.abort || rst) begin
            stripe_done = 1'b0;
            frame_done  = 1'b0;
        end

        if (bus.abort) begin
            state_d      = IDLE;
            wr_addr_d    = '0;
            win_base_d   = '0;
            col_d        = '0;
            row_d        = '0;
            stripe_idx_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its pre-edge value regardless of statement order.
        if (rst) begin
            state_q      <= IDLE;
            wr_addr_q    <= '0;
            win_base_q   <= '0;
            col_q        <= '0;
            row_q        <= '0;
            stripe_idx_q <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_addr_q    <= wr_addr_d;
            win_base_q   <= win_base_d;
            col_q        <= col_d;
            row_q        <= row_d;
            stripe_idx_q <= stripe_idx_d;
            // Buffer read latency is one cycle; an abort kills the in-flight read.
            out_valid_q  <= mem_rd & ~bus.abort;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.mem_wr      = mem_wr;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.mem_rd      = mem_rd;
    assign bus.win_base    = win_base_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.stripe_idx  = stripe_idx_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.stripe_done = stripe_done;
    assign bus.frame_done  = frame_done;

endmodule

// File: tb/tb_window_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_window_seq_ctrl
// Scoreboard bench for window_seq_ctrl. A scaled stripe geometry keeps a full
// 8-stripe frame short: PAD_W=10, IMG_W=8, OUT_ROWS=4 gives 60 pixels per
// stripe (wr_addr 0..59) and 32 windows per stripe (last win_base 3*10+7=37).
// Stimulus pushes expected write addresses, window bases and done pulses into
// queues; the monitor pops and compares whenever the DUT strobes an output.
// -----------------------------------------------------------------------------
module tb_window_seq_ctrl;

    localparam int PAD_W       = 10;
    localparam int IMG_W       = 8;
    localparam int OUT_ROWS    = 4;
    localparam int NUM_STRIPES = 8;
    localparam int LAST_WR     = 59;
    localparam int N_WIN       = 32;
    localparam int LAST_BASE   = 37;

    logic clk = 1'b0;
    logic rst;

    window_seq_ctrl_if bus ();

    window_seq_ctrl #(
        .PAD_W      (PAD_W),
        .IMG_W      (IMG_W),
        .OUT_ROWS   (OUT_ROWS),
        .NUM_STRIPES(NUM_STRIPES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_bad  = 0;
    int ov_cnt = 0;
    int fd_cnt = 0;
    bit mon_en = 1'b0;

    logic [13:0] wr_q[$];
    logic [13:0] rd_q[$];
    logic [2:0]  sdone_q[$];
    logic [2:0]  fdone_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.mem_wr) begin
                check("wr_expected", 32'(wr_q.size() != 0), 1);
                if (wr_q.size() != 0) check("wr_addr", bus.wr_addr, wr_q.pop_front());
            end
            if (bus.mem_rd) begin
                check("rd_expected", 32'(rd_q.size() != 0), 1);
                if (rd_q.size() != 0) check("win_base", bus.win_base, rd_q.pop_front());
            end
            if (bus.stripe_done) begin
                check("stripe_done_expected", 32'(sdone_q.size() != 0), 1);
                if (sdone_q.size() != 0) check("stripe_done_idx", bus.stripe_idx, sdone_q.pop_front());
                check("stripe_done_base", bus.win_base, LAST_BASE);
                check("stripe_done_with_rd", bus.mem_rd, 1);
            end
            if (bus.frame_done) begin
                fd_cnt++;
                check("frame_done_expected", 32'(fdone_q.size() != 0), 1);
                if (fdone_q.size() != 0) check("frame_done_idx", bus.stripe_idx, fdone_q.pop_front());
            end
            if (bus.out_valid) ov_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Load one stripe; caller is at posedge+1 with the DUT in LOAD.
    task automatic load_stripe(input bit gappy);
        int acc;
        int cyc;
        acc = 0;
        cyc = 0;
        for (int a = 0; a <= LAST_WR; a++) wr_q.push_back(14'(a));
        while (acc <= LAST_WR && cyc < 1000) begin
            bus.in_valid = gappy ? ((cyc % 3) != 2) : 1'b1;
            bus.start    = gappy && (cyc == 5);   // ignored outside IDLE
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) acc++;
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        check("load_accepted", acc, LAST_WR + 1);
        @(negedge clk);
        check("sweep_in_ready", bus.in_ready, 0);
        check("sweep_busy", bus.busy, 1);
        check("sweep_wr_addr", bus.wr_addr, 0);
        @(posedge clk);
        #1;
    endtask

    // Sweep one stripe through DRAIN; leaves caller at posedge+1 after DRAIN.
    task automatic sweep_stripe(input int s, input bit gappy);
        int reads;
        int cyc;
        int ov_base;
        bit done;
        logic [7:0] lfsr;
        reads   = 0;
        cyc     = 0;
        done    = 1'b0;
        lfsr    = 8'hA5;
        ov_base = ov_cnt;
        for (int r = 0; r < OUT_ROWS; r++)
            for (int c = 0; c < IMG_W; c++)
                rd_q.push_back(14'(r * PAD_W + c));
        sdone_q.push_back(3'(s));
        if (s == NUM_STRIPES - 1) fdone_q.push_back(3'(s));
        while (!done && cyc < 1000) begin
            bus.out_ready = gappy ? lfsr[0] : 1'b1;
            lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            @(negedge clk);
            if (bus.mem_rd) reads++;
            if (bus.stripe_done) done = 1'b1;
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.out_ready = 1'b0;
        check("sweep_finished", done, 1);
        check("sweep_reads", reads, N_WIN);
        @(negedge clk);
        check("drain_out_valid", bus.out_valid, 1);
        check("drain_busy", bus.busy, 1);
        check("drain_mem_rd", bus.mem_rd, 0);
        @(posedge clk);
        #1;
        check("windows_out", ov_cnt - ov_base, N_WIN);
    endtask

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        // Reset state.
        @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_mem_wr", bus.mem_wr, 0);
        check("rst_mem_rd", bus.mem_rd, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_wr_addr", bus.wr_addr, 0);
        check("rst_win_base", bus.win_base, 0);
        check("rst_stripe_idx", bus.stripe_idx, 0);

        // Inputs in IDLE are ignored.
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("idle_mem_wr", bus.mem_wr, 0);
        check("idle_mem_rd", bus.mem_rd, 0);
        check("idle_wr_addr", bus.wr_addr, 0);
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;

        // Full frame: stripe 0 continuous, later stripes with gaps.
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int s = 0; s < NUM_STRIPES; s++) begin
            load_stripe(s != 0);
            sweep_stripe(s, s != 0);
            @(negedge clk);
            if (s < NUM_STRIPES - 1) begin
                check("next_in_ready", bus.in_ready, 1);
                check("next_stripe_idx", bus.stripe_idx, s + 1);
            end else begin
                check("frame_end_busy", bus.busy, 0);
            end
            @(posedge clk);
            #1;
        end
        check("frame_done_count", fd_cnt, 1);

        // Abort mid-LOAD at wr_addr 40.
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int a = 0; a < 40; a++) wr_q.push_back(14'(a));
        bus.in_valid = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.abort    = 1'b1;
        @(negedge clk);
        check("abort_at_wr_addr", bus.wr_addr, 40);
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        @(negedge clk);
        check("abort_busy", bus.busy, 0);
        check("abort_wr_addr", bus.wr_addr, 0);
        check("abort_in_ready", bus.in_ready, 0);
        check("abort_out_valid", bus.out_valid, 0);

        // Restart reloads from 0, then reset mid-SWEEP at win_base 22.
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        load_stripe(1'b0);
        for (int r = 0; r < OUT_ROWS; r++)
            for (int c = 0; c < IMG_W; c++)
                if (r * PAD_W + c < 22) rd_q.push_back(14'(r * PAD_W + c));
        bus.out_ready = 1'b1;
        repeat (18) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        rst           = 1'b1;
        bus.abort     = 1'b1;
        bus.start     = 1'b1;
        @(negedge clk);
        check("rst_at_win_base", bus.win_base, 22);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        bus.abort = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_win_base", bus.win_base, 0);
        check("mid_rst_wr_addr", bus.wr_addr, 0);
        check("mid_rst_stripe_idx", bus.stripe_idx, 0);
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_mem_rd", bus.mem_rd, 0);
        check("mid_rst_in_ready", bus.in_ready, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("post_rst_idle", bus.busy, 0);

        // Everything expected was observed, nothing extra.
        check("wr_q_empty", wr_q.size(), 0);
        check("rd_q_empty", rd_q.size(), 0);
        check("sdone_q_empty", sdone_q.size(), 0);
        check("fdone_q_empty", fdone_q.size(), 0);
        check("frame_done_total", fd_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
